// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 set-2 keyboard receiver, decoder and event FIFO
// Optional auto-repeat suppression: define KBD_TYPEMATIC_FILTER_EN.
module ps2_kbd_rx #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic [7:0] key_ascii,
    output logic       key_break,
    output logic       key_ext,
    output logic       sflag,
    output logic       overflow,
    output logic       parity_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    logic          ps2c_s1, ps2c_s2, ps2c_h;
    logic          ps2d_s1, ps2d_s2;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [10:0]   sr;
    logic          frame_rdy;
    logic [TW-1:0] tcnt;

    assign fall = ps2c_h & ~ps2c_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2c_s1   <= 1'b0;
            ps2c_s2   <= 1'b0;
            ps2c_h    <= 1'b0;
            ps2d_s1   <= 1'b0;
            ps2d_s2   <= 1'b0;
            bit_cnt   <= 4'd0;
            sr        <= 11'd0;
            frame_rdy <= 1'b0;
            tcnt      <= '0;
        end else begin
            ps2c_s1   <= ps2_clk;
            ps2c_s2   <= ps2c_s1;
            ps2c_h    <= ps2c_s2;
            ps2d_s1   <= ps2_data;
            ps2d_s2   <= ps2d_s1;
            frame_rdy <= 1'b0;
            if (fall) begin
                sr[bit_cnt] <= ps2d_s2;
                tcnt        <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt   <= 4'd0;
                    frame_rdy <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is abandoned; pending prefixes survive.
                if (tcnt == TW'(TIMEOUT - 1)) begin
                    bit_cnt <= 4'd0;
                    tcnt    <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

    function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic sh);
        logic [7:0] l;
        case (c)
            8'h1C: l = 8'h61; 8'h32: l = 8'h62; 8'h21: l = 8'h63; 8'h23: l = 8'h64;
            8'h24: l = 8'h65; 8'h2B: l = 8'h66; 8'h34: l = 8'h67; 8'h33: l = 8'h68;
            8'h43: l = 8'h69; 8'h3B: l = 8'h6A; 8'h42: l = 8'h6B; 8'h4B: l = 8'h6C;
            8'h3A: l = 8'h6D; 8'h31: l = 8'h6E; 8'h44: l = 8'h6F; 8'h4D: l = 8'h70;
            8'h15: l = 8'h71; 8'h2D: l = 8'h72; 8'h1B: l = 8'h73; 8'h2C: l = 8'h74;
            8'h3C: l = 8'h75; 8'h2A: l = 8'h76; 8'h1D: l = 8'h77; 8'h22: l = 8'h78;
            8'h35: l = 8'h79; 8'h1A: l = 8'h7A;
            8'h45: l = 8'h30; 8'h16: l = 8'h31; 8'h1E: l = 8'h32; 8'h26: l = 8'h33;
            8'h25: l = 8'h34; 8'h2E: l = 8'h35; 8'h36: l = 8'h36; 8'h3D: l = 8'h37;
            8'h3E: l = 8'h38; 8'h46: l = 8'h39;
            8'h29: l = 8'h20; 8'h5A: l = 8'h0D; 8'h66: l = 8'h08;
            default: l = 8'h00;
        endcase
        // Only letters live at or above 0x61, so shift applies to them alone.
        if (sh && l >= 8'h61) l = l - 8'h20;
        return l;
    endfunction

    logic       frame_ok, byte_ok, is_prefix, is_shift, suppress, push_req;
    logic [7:0] code, ascii;
    logic       ext_pend, brk_pend;

    assign code      = sr[8:1];
    assign frame_ok  = frame_rdy && !sr[0] && sr[10] && (^sr[9:1]);
    assign is_prefix = (code == 8'hE0) || (code == 8'hF0);
    assign byte_ok   = frame_ok && !is_prefix;
    assign is_shift  = !ext_pend && ((code == 8'h12) || (code == 8'h59));
    assign ascii     = (ext_pend || brk_pend) ? 8'h00 : to_ascii(code, sflag);
    assign push_req  = byte_ok && !suppress;

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic [8:0] last_make;
    assign suppress = !brk_pend && ({ext_pend, code} == last_make);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_make <= 9'd0;
        end else if (byte_ok) begin
            if (!brk_pend)
                last_make <= {ext_pend, code};
            else if ({ext_pend, code} == last_make)
                last_make <= 9'd0;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            sflag      <= 1'b0;
        end else begin
            parity_err <= frame_rdy && !frame_ok;
            if (frame_ok) begin
                if (code == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (code == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    if (is_shift) sflag <= !brk_pend;
                end
            end
        end
    end

    logic [25:0] mem [DEPTH];
    logic [25:0] din, head;
    logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next;
    logic        full, pop, push_ok;

    assign din     = {ext_pend, brk_pend, code, ascii};
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = rd_en && key_valid;
    assign push_ok = push_req && (!full || pop);
    assign wr_next = wr_ptr + {{AW{1'b0}}, push_ok};
    assign rd_next = rd_ptr + {{AW{1'b0}}, pop};
    assign {key_ext, key_break, key_code, key_ascii} = head;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            key_valid <= 1'b0;
            head      <= 26'd0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            key_valid <= (wr_next != rd_next);
            // A push into the slot becoming head bypasses the storage read.
            if (push_ok && (wr_ptr == rd_next))
                head <= din;
            else
                head <= mem[rd_next[AW-1:0]];
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

endmodule
